// File: rtl/game_pkg.sv
// Shared types and the per-level zombie parameter table for the level sequencer.
// Table rows are levels 1..10; columns are zombie channels 0..3.
package game_pkg;

    typedef enum logic [2:0] {
        ST_TITLE     = 3'd0,
        ST_INTER     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_WIN       = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        SCR_TITLE     = 3'd0,
        SCR_PLAY      = 3'd1,
        SCR_WIN       = 3'd2,
        SCR_GAME_OVER = 3'd3,
        SCR_INTER     = 3'd4,
        SCR_PAUSED    = 3'd5
    } screen_t;

    localparam int TBL_ROWS = 10;
    localparam int TBL_COLS = 4;
    localparam int TBL_W    = 10;

    localparam logic [TBL_W-1:0] TITLE_SPEED = 10'd0;
    localparam logic [TBL_W-1:0] TITLE_DELAY = 10'd240;

    localparam logic [TBL_W-1:0] SPEED_TBL [TBL_ROWS][TBL_COLS] = '{
        '{10'd2,  10'd3,  10'd4,  10'd5},
        '{10'd4,  10'd5,  10'd6,  10'd7},
        '{10'd6,  10'd7,  10'd8,  10'd9},
        '{10'd8,  10'd9,  10'd10, 10'd11},
        '{10'd10, 10'd11, 10'd12, 10'd13},
        '{10'd12, 10'd13, 10'd14, 10'd15},
        '{10'd14, 10'd15, 10'd16, 10'd17},
        '{10'd16, 10'd17, 10'd18, 10'd19},
        '{10'd18, 10'd19, 10'd20, 10'd21},
        '{10'd20, 10'd21, 10'd22, 10'd23}
    };

    localparam logic [TBL_W-1:0] DELAY_TBL [TBL_ROWS][TBL_COLS] = '{
        '{10'd180, 10'd170, 10'd160, 10'd150},
        '{10'd165, 10'd155, 10'd145, 10'd135},
        '{10'd150, 10'd140, 10'd130, 10'd120},
        '{10'd135, 10'd125, 10'd115, 10'd105},
        '{10'd120, 10'd110, 10'd100, 10'd90},
        '{10'd105, 10'd95,  10'd85,  10'd75},
        '{10'd90,  10'd80,  10'd70,  10'd60},
        '{10'd75,  10'd65,  10'd55,  10'd45},
        '{10'd60,  10'd50,  10'd40,  10'd30},
        '{10'd45,  10'd35,  10'd25,  10'd15}
    };

    // Levels past the table reuse the hardest row.
    function automatic logic [3:0] tbl_row(input logic [3:0] lvl);
        if (lvl > 4'(TBL_ROWS))
            return 4'(TBL_ROWS - 1);
        return 4'(lvl - 4'd1);
    endfunction

    function automatic logic [TBL_W-1:0] speed_lookup(input logic [3:0] lvl, input logic [1:0] col);
        if (lvl == 4'd0)
            return TITLE_SPEED;
        return SPEED_TBL[tbl_row(lvl)][col];
    endfunction

    function automatic logic [TBL_W-1:0] delay_lookup(input logic [3:0] lvl, input logic [1:0] col);
        if (lvl == 4'd0)
            return TITLE_DELAY;
        return DELAY_TBL[tbl_row(lvl)][col];
    endfunction

    function automatic screen_t screen_of(input state_t st);
        case (st)
            ST_INTER:     return SCR_INTER;
            ST_PLAY:      return SCR_PLAY;
            ST_PAUSED:    return SCR_PAUSED;
            ST_WIN:       return SCR_WIN;
            ST_GAME_OVER: return SCR_GAME_OVER;
            default:      return SCR_TITLE;
        endcase
    endfunction

endpackage

// File: rtl/level_sequencer_edge_detect.sv
// Registered rising-edge detector for a level-sensitive button.
// The pulse appears the cycle after the input rises and lasts one cycle.
module edge_detect (
    input  logic Clk,
    input  logic Reset_h,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            prev <= din;
            rise <= din & ~prev;
        end
    end

endmodule

// File: rtl/level_sequencer.sv
// Game flow controller: title, intermission, play, pause, win and game-over screens,
// with per-level zombie speed/spawn-delay lookup.
module level_sequencer
    import game_pkg::*;
#(
    parameter int NUM_LEVELS   = 10,
    parameter int NUM_ZOMBIES  = 3,
    parameter int SPD_W        = 10,
    parameter int INTER_FRAMES = 120
) (
    input  logic                         Clk,
    input  logic                         Reset_h,
    input  logic                         frame_tick,
    input  logic                         Play,
    input  logic                         Pause,
    input  logic                         enemies,
    input  logic [3:0]                   player_health,
    output logic [3:0]                   level,
    output logic [2:0]                   event_screen,
    output logic                         new_level,
    output logic                         spawn_enable,
    output logic [NUM_ZOMBIES*SPD_W-1:0] zombie_speed,
    output logic [NUM_ZOMBIES*SPD_W-1:0] zombie_delay_spawn
);

    // A zero hold length would never expire, so it is stretched to one frame.
    localparam int INTER_EFF = (INTER_FRAMES < 1) ? 1 : INTER_FRAMES;
    localparam int CNT_W     = $clog2(INTER_EFF + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(INTER_EFF);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       LAST_LEVEL = 4'(NUM_LEVELS);

    state_t           state, state_nx;
    logic [3:0]       level_q, level_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             new_level_nx;
    logic             play_rise, pause_rise;

    edge_detect u_play_edge (
        .Clk     (Clk),
        .Reset_h (Reset_h),
        .din     (Play),
        .rise    (play_rise)
    );

    edge_detect u_pause_edge (
        .Clk     (Clk),
        .Reset_h (Reset_h),
        .din     (Pause),
        .rise    (pause_rise)
    );

    always_comb begin
        state_nx     = state;
        level_nx     = level_q;
        cnt_nx       = cnt_q;
        new_level_nx = 1'b0;
        case (state)
            ST_TITLE: begin
                if (play_rise) begin
                    state_nx = ST_INTER;
                    level_nx = 4'd1;
                    cnt_nx   = CNT_RELOAD;
                end
            end
            ST_INTER: begin
                if (frame_tick) begin
                    if (cnt_q <= CNT_ONE) begin
                        state_nx     = ST_PLAY;
                        new_level_nx = 1'b1;
                        cnt_nx       = '0;
                    end else begin
                        cnt_nx = cnt_q - CNT_ONE;
                    end
                end
            end
            ST_PLAY: begin
                if (player_health == 4'd0) begin
                    state_nx = ST_GAME_OVER;
                    cnt_nx   = CNT_RELOAD;
                end else if (!enemies && level_q == LAST_LEVEL) begin
                    state_nx = ST_WIN;
                end else if (!enemies) begin
                    state_nx = ST_INTER;
                    level_nx = 4'(level_q + 4'd1);
                    cnt_nx   = CNT_RELOAD;
                end else if (pause_rise) begin
                    state_nx = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (pause_rise)
                    state_nx = ST_PLAY;
            end
            ST_WIN: begin
                if (play_rise) begin
                    state_nx = ST_INTER;
                    level_nx = 4'd1;
                    cnt_nx   = CNT_RELOAD;
                end
            end
            ST_GAME_OVER: begin
                // A restart press beats a hold expiring on the same cycle.
                if (play_rise) begin
                    state_nx = ST_INTER;
                    level_nx = 4'd1;
                    cnt_nx   = CNT_RELOAD;
                end else if (frame_tick) begin
                    if (cnt_q <= CNT_ONE) begin
                        state_nx = ST_TITLE;
                        level_nx = 4'd0;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_nx = ST_TITLE;
                level_nx = 4'd0;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state     <= ST_TITLE;
            level_q   <= 4'd0;
            cnt_q     <= '0;
            new_level <= 1'b0;
        end else begin
            state     <= state_nx;
            level_q   <= level_nx;
            cnt_q     <= cnt_nx;
            new_level <= new_level_nx;
        end
    end

    assign event_screen = 3'(screen_of(state));
    assign spawn_enable = (state == ST_PLAY);
    assign level        = (state == ST_INTER || state == ST_PLAY || state == ST_PAUSED) ? level_q : 4'd0;

    // Channels beyond the table width share the last column.
    for (genvar z = 0; z < NUM_ZOMBIES; z++) begin : g_zombie
        localparam logic [1:0] COL = (z >= TBL_COLS) ? 2'(TBL_COLS - 1) : 2'(z);
        assign zombie_speed[z*SPD_W +: SPD_W]       = SPD_W'(speed_lookup(level_q, COL));
        assign zombie_delay_spawn[z*SPD_W +: SPD_W] = SPD_W'(delay_lookup(level_q, COL));
    end

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer with NUM_LEVELS=3, INTER_FRAMES=2, three zombie channels.
module tb_level_sequencer;

    localparam int NZ = 3;
    localparam int SW = 10;

    localparam logic [NZ*SW-1:0] TITLE_SPD = {10'd0, 10'd0, 10'd0};
    localparam logic [NZ*SW-1:0] TITLE_DLY = {10'd240, 10'd240, 10'd240};
    localparam logic [NZ*SW-1:0] L1_SPD    = {10'd4, 10'd3, 10'd2};
    localparam logic [NZ*SW-1:0] L2_DLY    = {10'd145, 10'd155, 10'd165};
    localparam logic [NZ*SW-1:0] L3_SPD    = {10'd8, 10'd7, 10'd6};
    localparam logic [NZ*SW-1:0] L3_DLY    = {10'd130, 10'd140, 10'd150};

    logic           Clk = 1'b0;
    logic           Reset_h;
    logic           frame_tick;
    logic           Play;
    logic           Pause;
    logic           enemies;
    logic [3:0]     player_health;
    logic [3:0]     level;
    logic [2:0]     event_screen;
    logic           new_level;
    logic           spawn_enable;
    logic [NZ*SW-1:0] zombie_speed;
    logic [NZ*SW-1:0] zombie_delay_spawn;

    int n_cmp = 0;
    int n_err = 0;

    level_sequencer #(
        .NUM_LEVELS   (3),
        .NUM_ZOMBIES  (NZ),
        .SPD_W        (SW),
        .INTER_FRAMES (2)
    ) dut (
        .Clk                (Clk),
        .Reset_h            (Reset_h),
        .frame_tick         (frame_tick),
        .Play               (Play),
        .Pause              (Pause),
        .enemies            (enemies),
        .player_health      (player_health),
        .level              (level),
        .event_screen       (event_screen),
        .new_level          (new_level),
        .spawn_enable       (spawn_enable),
        .zombie_speed       (zombie_speed),
        .zombie_delay_spawn (zombie_delay_spawn)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    task automatic press_play();
        Play = 1'b1;
        cyc(1);
        Play = 1'b0;
        cyc(1);
    endtask

    task automatic press_pause();
        Pause = 1'b1;
        cyc(1);
        Pause = 1'b0;
        cyc(1);
    endtask

    task automatic clear_level();
        enemies = 1'b0;
        cyc(1);
        enemies = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_h = 1'b1; frame_tick = 1'b0; Play = 1'b0; Pause = 1'b0;
        enemies = 1'b1; player_health = 4'd5;
        cyc(2);
        chk("rst_screen", 32'(event_screen), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_new_level", 32'(new_level), 0);
        chk("rst_spawn", 32'(spawn_enable), 0);
        chk("rst_zspeed", 32'(zombie_speed), 32'(TITLE_SPD));
        chk("rst_zdelay", 32'(zombie_delay_spawn), 32'(TITLE_DLY));
        Reset_h = 1'b0;
        cyc(1);
        chk("title_idle", 32'(event_screen), 0);

        // Start: title -> intermission -> play level 1
        press_play();
        chk("start_screen", 32'(event_screen), 4);
        chk("start_level", 32'(level), 1);
        chk("start_spawn", 32'(spawn_enable), 0);
        chk("l1_zspeed", 32'(zombie_speed), 32'(L1_SPD));
        ftick();
        chk("inter_hold", 32'(event_screen), 4);
        chk("inter_nl", 32'(new_level), 0);
        ftick();
        chk("play1_screen", 32'(event_screen), 1);
        chk("play1_new_level", 32'(new_level), 1);
        chk("play1_spawn", 32'(spawn_enable), 1);
        chk("play1_level", 32'(level), 1);
        cyc(1);
        chk("play1_nl_drop", 32'(new_level), 0);

        // Level clear -> level 2
        clear_level();
        chk("l2_inter_screen", 32'(event_screen), 4);
        chk("l2_inter_level", 32'(level), 2);
        chk("l2_zdelay", 32'(zombie_delay_spawn), 32'(L2_DLY));
        ftick(); ftick();
        chk("play2_screen", 32'(event_screen), 1);
        chk("play2_new_level", 32'(new_level), 1);
        cyc(1);

        // Pause held 10 cycles toggles once; health/enemies ignored while paused
        Pause = 1'b1;
        cyc(10);
        chk("pause_screen", 32'(event_screen), 5);
        chk("pause_level", 32'(level), 2);
        chk("pause_spawn", 32'(spawn_enable), 0);
        player_health = 4'd0; enemies = 1'b0;
        cyc(2);
        chk("pause_ignore", 32'(event_screen), 5);
        player_health = 4'd5; enemies = 1'b1; Pause = 1'b0;
        cyc(1);
        press_pause();
        chk("resume_screen", 32'(event_screen), 1);
        chk("resume_nl", 32'(new_level), 0);
        chk("resume_level", 32'(level), 2);
        chk("resume_spawn", 32'(spawn_enable), 1);
        cyc(1);
        chk("resume_nl2", 32'(new_level), 0);

        // Level 3 then win
        clear_level();
        ftick(); ftick();
        chk("play3_level", 32'(level), 3);
        chk("l3_zspeed", 32'(zombie_speed), 32'(L3_SPD));
        chk("l3_zdelay", 32'(zombie_delay_spawn), 32'(L3_DLY));
        enemies = 1'b0;
        cyc(1);
        chk("win_screen", 32'(event_screen), 2);
        chk("win_level", 32'(level), 0);
        chk("win_spawn", 32'(spawn_enable), 0);
        cyc(3);
        chk("win_hold", 32'(event_screen), 2);
        press_play();
        chk("win_restart_screen", 32'(event_screen), 4);
        chk("win_restart_level", 32'(level), 1);
        enemies = 1'b1;
        ftick(); ftick();
        chk("replay_screen", 32'(event_screen), 1);

        // Health and enemies both zero: game over wins priority, then hold expires to title
        player_health = 4'd0; enemies = 1'b0;
        cyc(1);
        chk("go_screen", 32'(event_screen), 3);
        chk("go_level", 32'(level), 0);
        player_health = 4'd5; enemies = 1'b1;
        ftick();
        chk("go_hold", 32'(event_screen), 3);
        ftick();
        chk("go_title", 32'(event_screen), 0);
        chk("go_title_zspeed", 32'(zombie_speed), 32'(TITLE_SPD));

        // Play held through a whole game: no restart from WIN until re-pressed
        Play = 1'b1;
        cyc(2);
        chk("held_start", 32'(event_screen), 4);
        ftick(); ftick();
        clear_level(); ftick(); ftick();
        clear_level(); ftick(); ftick();
        chk("held_l3", 32'(level), 3);
        enemies = 1'b0;
        cyc(1);
        chk("held_win", 32'(event_screen), 2);
        cyc(5);
        chk("held_no_restart", 32'(event_screen), 2);
        Play = 1'b0;
        cyc(2);
        chk("released_win", 32'(event_screen), 2);
        enemies = 1'b1;
        press_play();
        chk("repress_screen", 32'(event_screen), 4);
        chk("repress_level", 32'(level), 1);

        // Play edge from game over restarts at level 1
        ftick(); ftick();
        player_health = 4'd0;
        cyc(1);
        player_health = 4'd5;
        chk("go2_screen", 32'(event_screen), 3);
        press_play();
        chk("go_restart_screen", 32'(event_screen), 4);
        chk("go_restart_level", 32'(level), 1);

        // Play edge and hold expiry on the same cycle: restart wins
        ftick(); ftick();
        player_health = 4'd0;
        cyc(1);
        player_health = 4'd5;
        ftick();
        chk("go3_screen", 32'(event_screen), 3);
        Play = 1'b1;
        cyc(1);
        Play = 1'b0; frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        chk("simul_screen", 32'(event_screen), 4);
        chk("simul_level", 32'(level), 1);

        // Reset mid level 2
        ftick(); ftick();
        clear_level(); ftick(); ftick();
        chk("mid_l2_level", 32'(level), 2);
        Reset_h = 1'b1; enemies = 1'b0; Pause = 1'b1;
        cyc(1);
        chk("mid_rst_screen", 32'(event_screen), 0);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_nl", 32'(new_level), 0);
        chk("mid_rst_spawn", 32'(spawn_enable), 0);
        chk("mid_rst_zspeed", 32'(zombie_speed), 32'(TITLE_SPD));
        chk("mid_rst_zdelay", 32'(zombie_delay_spawn), 32'(TITLE_DLY));
        Reset_h = 1'b0; Pause = 1'b0; enemies = 1'b1;
        cyc(3);
        chk("post_rst_title", 32'(event_screen), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
